// File: rtl/fir_seq_ctrl.sv
// Sequential 3-tap FIR controller: one shared signed 3x5 multiplier, time-multiplexed over three MAC cycles.
// Define FIR_SEQ_CTRL_SAT_EN to saturate out-of-range sums on o_y instead of wrapping them.
module fir_seq_ctrl #(
    parameter logic signed [4:0] C0 = 5'sd8,
    parameter logic signed [4:0] C1 = 5'sd5,
    parameter logic signed [4:0] C2 = 5'sd10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic signed [2:0] i_x,
    output logic              o_valid,
    input  logic              i_ready,
    output logic signed [6:0] o_y,
    output logic              o_ovf
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MAC0 = 3'd1,
        MAC1 = 3'd2,
        MAC2 = 3'd3,
        OUT  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic signed [2:0] x0, x1, x2;
    logic signed [8:0] acc;
    logic signed [2:0] x_sel;
    logic signed [4:0] c_sel;
    logic signed [7:0] x_ext, c_ext, prod;
    logic signed [8:0] prod_ext, acc_base, sum;
    logic              accept;

    function automatic logic out_of_range(input logic signed [8:0] v);
        return (v > 9'sd63) || (v < -9'sd64);
    endfunction

    function automatic logic signed [6:0] fit7(input logic signed [8:0] v);
`ifdef FIR_SEQ_CTRL_SAT_EN
        if (v > 9'sd63)
            return 7'sd63;
        else if (v < -9'sd64)
            return -7'sd64;
        else
            return v[6:0];
`else
        return v[6:0];
`endif
    endfunction

    assign accept = i_valid & o_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MAC0;
            MAC0:    state_nxt = MAC1;
            MAC1:    state_nxt = MAC2;
            MAC2:    state_nxt = OUT;
            OUT:     if (i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs plus the tap select feeding the shared multiplier.
    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        x_sel   = x0;
        c_sel   = C0;
        case (state)
            IDLE: o_ready = 1'b1;
            MAC1: begin
                x_sel = x1;
                c_sel = C1;
            end
            MAC2: begin
                x_sel = x2;
                c_sel = C2;
            end
            OUT:  o_valid = 1'b1;
            default: ;
        endcase
    end

    assign x_ext    = {{5{x_sel[2]}}, x_sel};
    assign c_ext    = {{3{c_sel[4]}}, c_sel};
    assign prod     = x_ext * c_ext;
    assign prod_ext = {prod[7], prod};
    assign acc_base = (state == MAC0) ? 9'sd0 : acc;
    assign sum      = acc_base + prod_ext;

    // Datapath: delay line shifts on accept; o_y/o_ovf update only when MAC2 completes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            x0    <= '0;
            x1    <= '0;
            x2    <= '0;
            acc   <= '0;
            o_y   <= '0;
            o_ovf <= 1'b0;
        end else begin
            if (accept) begin
                x2 <= x1;
                x1 <= x0;
                x0 <= i_x;
            end
            if (state == MAC0 || state == MAC1 || state == MAC2)
                acc <= sum;
            if (state == MAC2) begin
                o_y <= fit7(sum);
                if (out_of_range(sum))
                    o_ovf <= 1'b1;
            end
        end
    end

endmodule
